spl_rx: RTL and testbench

SPL_RX -- requirements
Module: spl_rx

---
 rtl/spl_rx.sv | 154 +++++++++++++++
 tb/tb_spl_rx.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spl_rx.sv
// spl_rx: receiver for the serial LED transmitter link.
// Ports: clk, rst (sync, active-low); led_clk, led_sout, led_clrn, LED_PEN
// asynchronous serial inputs; P_Data last good frame, frame_valid pulse,
// frame_err sticky error, bit_cnt bits in current frame, busy frame active.
module spl_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     led_clk,
    input  logic                     led_sout,
    input  logic                     led_clrn,
    input  logic                     LED_PEN,
    output logic [WIDTH-1:0]         P_Data,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic [$clog2(WIDTH):0]   bit_cnt,
    output logic                     busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    // Pin order {LED_PEN, led_clrn, led_sout, led_clk}; idle levels.
    localparam logic [3:0] PIN_IDLE = 4'b0100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_e;

    logic [3:0]       sync_q [SYNC_STAGES];
    logic             lclk_dly_q;
    logic             pen_dly_q;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pdata_q, pdata_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             first_q, first_d;

    logic lclk_s, sout_s, clrn_s, pen_s;
    logic shift_ev, latch_ev;

    assign lclk_s = sync_q[SYNC_STAGES-1][0];
    assign sout_s = sync_q[SYNC_STAGES-1][1];
    assign clrn_s = sync_q[SYNC_STAGES-1][2];
    assign pen_s  = sync_q[SYNC_STAGES-1][3];

    assign shift_ev = lclk_s & ~lclk_dly_q;
    assign latch_ev = pen_s & ~pen_dly_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= PIN_IDLE;
            end
            lclk_dly_q <= 1'b0;
            pen_dly_q  <= 1'b0;
        end else begin
            sync_q[0] <= {LED_PEN, led_clrn, led_sout, led_clk};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            lclk_dly_q <= lclk_s;
            pen_dly_q  <= pen_s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            pdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        pdata_d = pdata_q;
        valid_d = 1'b0;
        err_d   = err_q;
        first_d = first_q;
        if (!clrn_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else begin
            // Latch is resolved first so a coincident shift sees the
            // pre-shift register and opens a fresh frame.
            if (latch_ev) begin
                if (state_q == FULL) begin
                    pdata_d = shreg_q;
                    valid_d = 1'b1;
                    if (first_q) begin
                        err_d = 1'b0;
                    end
                end else begin
                    err_d = 1'b1;
                end
                first_d = 1'b0;
                state_d = IDLE;
                cnt_d   = '0;
            end
            if (shift_ev) begin
                shreg_d = {shreg_q[WIDTH-2:0], sout_s};
                unique case (state_d)
                    IDLE: begin
                        state_d = SHIFT;
                        cnt_d   = CNT_ONE;
                    end
                    SHIFT: begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == CNT_FULL) begin
                            state_d = FULL;
                        end
                    end
                    FULL: begin
                        err_d = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    assign P_Data      = pdata_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign bit_cnt     = cnt_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spl_rx.sv
// tb_spl_rx: self-checking bench for spl_rx with a queue-based frame model.
// Drives and samples on the falling clk edge.
module tb_spl_rx;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         led_clk = 1'b0;
    logic         led_sout = 1'b0;
    logic         led_clrn = 1'b1;
    logic         LED_PEN = 1'b0;
    logic [W-1:0] P_Data;
    logic         frame_valid;
    logic         frame_err;
    logic [5:0]   bit_cnt;
    logic         busy;

    int total = 0;
    int bad = 0;

    bit           mq[$];
    logic [W-1:0] m_pdata;
    bit           m_err;
    bit           m_first;
    bit           exp_v;

    logic         ob_v2, ob_v3, ob_v4;
    logic [W-1:0] ob_pd;

    spl_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .led_clk(led_clk),
        .led_sout(led_sout),
        .led_clrn(led_clrn),
        .LED_PEN(LED_PEN),
        .P_Data(P_Data),
        .frame_valid(frame_valid),
        .frame_err(frame_err),
        .bit_cnt(bit_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int mcnt();
        return (mq.size() > W) ? W : mq.size();
    endfunction

    function automatic logic [W-1:0] m_frame();
        logic [W-1:0] v;
        int base;
        base = mq.size() - W;
        for (int i = 0; i < W; i++) v[W-1-i] = mq[base+i];
        return v;
    endfunction

    task automatic m_shift(input bit b);
        mq.push_back(b);
        if (mq.size() > W) m_err = 1'b1;
    endtask

    task automatic m_latch();
        if (mq.size() >= W) begin
            m_pdata = m_frame();
            exp_v = 1'b1;
            if (m_first) m_err = 1'b0;
        end else begin
            exp_v = 1'b0;
            m_err = 1'b1;
        end
        mq.delete();
        m_first = 1'b0;
    endtask

    task automatic m_reset();
        mq.delete();
        m_pdata = '0;
        m_err = 1'b0;
        m_first = 1'b1;
    endtask

    task automatic send_bit(input bit b);
        led_sout = b;
        led_clk = 1'b0;
        tick(4);
        led_clk = 1'b1;
        tick(4);
        m_shift(b);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_latch();
        m_latch();
        LED_PEN = 1'b1;
        tick(2);
        ob_v2 = frame_valid;
        tick(1);
        ob_v3 = frame_valid;
        ob_pd = P_Data;
        tick(1);
        ob_v4 = frame_valid;
        LED_PEN = 1'b0;
        tick(4);
    endtask

    task automatic hold_reset();
        led_clk = 1'b0;
        led_sout = 1'b0;
        LED_PEN = 1'b0;
        led_clrn = 1'b1;
        rst = 1'b0;
        tick(3);
    endtask

    task automatic release_reset();
        rst = 1'b1;
        tick(2);
        m_reset();
    endtask

    task automatic test_reset();
        hold_reset();
        total++;
        if (P_Data !== '0) begin
            bad++; $display("FAIL rst_pdata got=%h exp=0", P_Data);
        end
        total++;
        if ({frame_valid, frame_err, busy} !== 3'b000) begin
            bad++;
            $display("FAIL rst_flags got=%b exp=000",
                     {frame_valid, frame_err, busy});
        end
        total++;
        if (bit_cnt !== 6'd0) begin
            bad++; $display("FAIL rst_cnt got=%0d exp=0", bit_cnt);
        end
        release_reset();
    endtask

    task automatic test_full_frame();
        send_bits(64'hFFFF_FF5A, W);
        total++;
        if (bit_cnt !== 6'(mcnt()) || busy !== 1'b1) begin
            bad++;
            $display("FAIL full_cnt got=%0d/%b exp=%0d/1",
                     bit_cnt, busy, mcnt());
        end
        do_latch();
        total++;
        if (ob_v2 !== 1'b0 || ob_v3 !== 1'b1 || ob_v4 !== 1'b0) begin
            bad++;
            $display("FAIL full_latency got=%b%b%b exp=010",
                     ob_v2, ob_v3, ob_v4);
        end
        total++;
        if (ob_pd !== 32'hFFFF_FF5A) begin
            bad++; $display("FAIL full_pdata got=%h exp=ffffff5a", ob_pd);
        end
        total++;
        if (frame_err !== 1'b0 || bit_cnt !== 6'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_after got=%b/%0d/%b exp=0/0/0",
                     frame_err, bit_cnt, busy);
        end
    endtask

    task automatic test_short();
        logic [W-1:0] prev;
        prev = m_pdata;
        send_bits(64'($urandom()), 20);
        total++;
        if (bit_cnt !== 6'd20 || busy !== 1'b1) begin
            bad++;
            $display("FAIL short_cnt got=%0d/%b exp=20/1", bit_cnt, busy);
        end
        do_latch();
        total++;
        if (ob_v3 !== exp_v || ob_v2 !== 1'b0 || ob_v4 !== 1'b0) begin
            bad++;
            $display("FAIL short_valid got=%b%b%b exp=0%b0",
                     ob_v2, ob_v3, ob_v4, exp_v);
        end
        total++;
        if (P_Data !== prev) begin
            bad++; $display("FAIL short_pdata got=%h exp=%h", P_Data, prev);
        end
        total++;
        if (frame_err !== 1'b1 || bit_cnt !== 6'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL short_after got=%b/%0d/%b exp=1/0/0",
                     frame_err, bit_cnt, busy);
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] w;
        bit b;
        hold_reset();
        release_reset();
        send_bits(64'($urandom()), W);
        do_latch();
        w = $urandom();
        b = 1'($urandom());
        send_bits(64'(w), W);
        total++;
        if (frame_err !== 1'b0 || bit_cnt !== 6'd32) begin
            bad++;
            $display("FAIL ovr_pre got=%b/%0d exp=0/32", frame_err, bit_cnt);
        end
        send_bit(b);
        total++;
        if (frame_err !== 1'b1 || bit_cnt !== 6'd32 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ovr_err got=%b/%0d/%b exp=1/32/1",
                     frame_err, bit_cnt, busy);
        end
        do_latch();
        total++;
        if (ob_v3 !== 1'b1 || ob_pd !== {w[W-2:0], b}) begin
            bad++;
            $display("FAIL ovr_pdata got=%b/%h exp=1/%h",
                     ob_v3, ob_pd, {w[W-2:0], b});
        end
        total++;
        if (frame_err !== 1'b1) begin
            bad++; $display("FAIL ovr_sticky got=%b exp=1", frame_err);
        end
    endtask

    task automatic test_clrn();
        hold_reset();
        release_reset();
        send_bits(64'($urandom()), 10);
        led_clrn = 1'b0;
        tick(4);
        led_clrn = 1'b1;
        tick(4);
        mq.delete();
        total++;
        if (bit_cnt !== 6'd0 || busy !== 1'b0 || P_Data !== m_pdata) begin
            bad++;
            $display("FAIL clrn_clear got=%0d/%b/%h exp=0/0/%h",
                     bit_cnt, busy, P_Data, m_pdata);
        end
        send_bits(64'h0000_00A5, W);
        do_latch();
        total++;
        if (ob_v3 !== 1'b1 || ob_pd !== 32'h0000_00A5) begin
            bad++;
            $display("FAIL clrn_pdata got=%b/%h exp=1/000000a5", ob_v3, ob_pd);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL clrn_err got=%b exp=0", frame_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v;
        bit b2;
        v = $urandom();
        b2 = 1'($urandom());
        send_bits(64'(v), W);
        m_latch();
        m_shift(b2);
        led_sout = b2;
        led_clk = 1'b0;
        tick(4);
        led_clk = 1'b1;
        LED_PEN = 1'b1;
        tick(2);
        ob_v2 = frame_valid;
        tick(1);
        ob_v3 = frame_valid;
        ob_pd = P_Data;
        tick(1);
        ob_v4 = frame_valid;
        LED_PEN = 1'b0;
        tick(4);
        total++;
        if (ob_v3 !== 1'b1 || ob_pd !== v) begin
            bad++;
            $display("FAIL align_pdata got=%b/%h exp=1/%h", ob_v3, ob_pd, v);
        end
        total++;
        if (bit_cnt !== 6'(mcnt()) || busy !== 1'b1) begin
            bad++;
            $display("FAIL align_cnt got=%0d/%b exp=%0d/1",
                     bit_cnt, busy, mcnt());
        end
        total++;
        if (frame_err !== m_err) begin
            bad++;
            $display("FAIL align_err got=%b exp=%b", frame_err, m_err);
        end
    endtask

    task automatic test_reset_midframe();
        send_bits(64'($urandom()), 16);
        hold_reset();
        total++;
        if ({P_Data, frame_valid, frame_err, bit_cnt, busy} !== '0) begin
            bad++;
            $display("FAIL midrst_out got=%h/%b/%b/%0d/%b exp=all 0",
                     P_Data, frame_valid, frame_err, bit_cnt, busy);
        end
        release_reset();
        send_bits(64'h1234_5678, W);
        do_latch();
        total++;
        if (ob_v3 !== 1'b1 || ob_pd !== 32'h1234_5678) begin
            bad++;
            $display("FAIL midrst_pdata got=%b/%h exp=1/12345678", ob_v3, ob_pd);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL midrst_err got=%b exp=0", frame_err);
        end
    endtask

    task automatic test_random();
        int n;
        hold_reset();
        release_reset();
        for (int k = 0; k < 14; k++) begin
            n = $urandom_range(1, 36);
            if ($urandom_range(0, 4) == 0) begin
                send_bits({$urandom(), $urandom()}, $urandom_range(1, 8));
                led_clrn = 1'b0;
                tick(4);
                led_clrn = 1'b1;
                tick(4);
                mq.delete();
            end
            send_bits({$urandom(), $urandom()}, n);
            total++;
            if (bit_cnt !== 6'(mcnt()) || frame_err !== m_err) begin
                bad++;
                $display("FAIL rnd%0d_pre got=%0d/%b exp=%0d/%b",
                         k, bit_cnt, frame_err, mcnt(), m_err);
            end
            do_latch();
            total++;
            if (ob_v3 !== exp_v || ob_pd !== m_pdata) begin
                bad++;
                $display("FAIL rnd%0d_latch got=%b/%h exp=%b/%h",
                         k, ob_v3, ob_pd, exp_v, m_pdata);
            end
            total++;
            if (frame_err !== m_err || bit_cnt !== 6'd0) begin
                bad++;
                $display("FAIL rnd%0d_post got=%b/%0d exp=%b/0",
                         k, frame_err, bit_cnt, m_err);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_full_frame();
        test_short();
        test_overrun();
        test_clrn();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
